// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if
//   Bundles the pipeline-side request signals and the CP0/fetch-side
//   command signals of the exception sequencer.
//   master : the pipeline/CP0 environment (drives flags, MTC0, read-back)
//   slave  : exc_ctrl (drives CP0 control word, write data, redirect)
interface exc_ctrl_if;
    // Requests from the committing instruction
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_sys;
    logic        exc_bp;
    logic        exc_ri;
    logic        exc_ov;
    logic        in_delay_slot;
    logic [31:0] bad_addr;
    logic [31:0] pc_plus8;
    logic        eret;
    logic        mtc0_wen;
    logic [4:0]  mtc0_sel;
    logic [31:0] mtc0_data;
    // CP0 read-back
    logic [31:0] status_in;
    logic [31:0] cause_in;
    logic [31:0] epc_in;
    // Commands to CP0 and fetch
    logic [13:0] cp0_control;
    logic [31:0] cp0_data;
    logic [31:0] cp0_pc;
    logic        busy;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_target;

    modport master (
        output exc_adel, exc_ades, exc_sys, exc_bp, exc_ri, exc_ov,
        output in_delay_slot, bad_addr, pc_plus8, eret,
        output mtc0_wen, mtc0_sel, mtc0_data,
        output status_in, cause_in, epc_in,
        input  cp0_control, cp0_data, cp0_pc, busy, flush,
        input  pc_redirect, redirect_target
    );

    modport slave (
        input  exc_adel, exc_ades, exc_sys, exc_bp, exc_ri, exc_ov,
        input  in_delay_slot, bad_addr, pc_plus8, eret,
        input  mtc0_wen, mtc0_sel, mtc0_data,
        input  status_in, cause_in, epc_in,
        output cp0_control, cp0_data, cp0_pc, busy, flush,
        output pc_redirect, redirect_target
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl
//   Exception/interrupt sequencer between the EX/MEM stage and CP0.
//   In IDLE it accepts an exception (or interrupt) or an ERET, and passes
//   MTC0 writes straight through to CP0. An exception runs
//   IDLE -> COMMIT (CP0 write of EPC/BD/ExcCode/EXL[/BadVAddr])
//        -> REDIRECT (fetch from EXC_VECTOR) -> IDLE.
//   An ERET runs IDLE -> ERET_R (clear EXL, fetch from EPC) -> IDLE.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high; returns to IDLE, forces outputs to 0
//     bus   : exc_ctrl_if.slave (request inputs, CP0 read-back, commands)
//
//   Build option:
//     EXC_INTERRUPT_EN : when defined, a pending unmasked interrupt is taken
//                        in IDLE at top priority (ExcCode_Sel 000). When
//                        undefined, status_in/cause_in are ignored.
//
//   cp0_control layout:
//     [13] EPC_IN_Sel  [12] BadAddr_wen  [11] BadAddr_IN_Sel [10] Status_wen
//     [9]  EXL value   [8]  EXL_wen      [7]  BD_wen         [6]  BD value
//     [5]  Cause_wen   [4]  ExcCode_wen  [3:1] ExcCode_Sel   [0]  EPC_wen
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);
    localparam int B_EPC_IN_SEL = 13;
    localparam int B_BAD_WEN    = 12;
    localparam int B_BAD_IN_SEL = 11;
    localparam int B_STATUS_WEN = 10;
    localparam int B_EXL_VAL    = 9;
    localparam int B_EXL_WEN    = 8;
    localparam int B_BD_WEN     = 7;
    localparam int B_BD_VAL     = 6;
    localparam int B_CAUSE_WEN  = 5;
    localparam int B_CODE_WEN   = 4;
    localparam int B_EPC_WEN    = 0;

    localparam logic [2:0] CODE_INT  = 3'b000;
    localparam logic [2:0] CODE_ADEL = 3'b001;
    localparam logic [2:0] CODE_ADES = 3'b010;
    localparam logic [2:0] CODE_SYS  = 3'b011;
    localparam logic [2:0] CODE_BP   = 3'b100;
    localparam logic [2:0] CODE_RI   = 3'b101;
    localparam logic [2:0] CODE_OV   = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        REDIRECT = 2'd2,
        ERET_R   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic [31:0] pc8_q, pc8_d;

    logic        irq_pending;
    logic        exc_any;
    logic [2:0]  exc_code;

`ifdef EXC_INTERRUPT_EN
    // Interrupts enabled (IE=1), not already in exception level (EXL=0),
    // and at least one pending line unmasked by IM.
    assign irq_pending = bus.status_in[0] & ~bus.status_in[1] &
                         (|(bus.cause_in[15:8] & bus.status_in[15:8]));
    logic unused_irq_bits;
    assign unused_irq_bits = ^{bus.status_in[31:16], bus.status_in[7:2],
                               bus.cause_in[31:16], bus.cause_in[7:0]};
`else
    assign irq_pending = 1'b0;
    logic unused_irq_bits;
    assign unused_irq_bits = ^{bus.status_in, bus.cause_in};
`endif

    // Priority encoder; AdES is the lowest-priority source, so it is the
    // fall-through when nothing above it is raised.
    always_comb begin
        exc_any = irq_pending | bus.exc_adel | bus.exc_ades | bus.exc_sys |
                  bus.exc_bp | bus.exc_ri | bus.exc_ov;
        if (irq_pending)        exc_code = CODE_INT;
        else if (bus.exc_adel)  exc_code = CODE_ADEL;
        else if (bus.exc_ri)    exc_code = CODE_RI;
        else if (bus.exc_ov)    exc_code = CODE_OV;
        else if (bus.exc_sys)   exc_code = CODE_SYS;
        else if (bus.exc_bp)    exc_code = CODE_BP;
        else                    exc_code = CODE_ADES;
    end

    // Next state and latched exception context
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        bd_d       = bd_q;
        bad_addr_d = bad_addr_q;
        pc8_d      = pc8_q;
        case (state_q)
            IDLE: begin
                if (exc_any) begin
                    state_d    = COMMIT;
                    code_d     = exc_code;
                    bd_d       = bus.in_delay_slot;
                    bad_addr_d = bus.bad_addr;
                    pc8_d      = bus.pc_plus8;
                end else if (bus.eret) begin
                    state_d = ERET_R;
                end
            end
            COMMIT:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            ERET_R:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            code_q     <= 3'b000;
            bd_q       <= 1'b0;
            bad_addr_q <= 32'h0;
            pc8_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            bd_q       <= bd_d;
            bad_addr_q <= bad_addr_d;
            pc8_q      <= pc8_d;
        end
    end

    // Output decode. Everything is a function of the registered state and
    // latched context, except the MTC0 pass-through in IDLE. Reset forces
    // all outputs low so an aborted COMMIT never reaches CP0.
    always_comb begin
        bus.cp0_control     = 14'h0;
        bus.cp0_data        = 32'h0;
        bus.cp0_pc          = 32'h0;
        bus.busy            = 1'b0;
        bus.flush           = 1'b0;
        bus.pc_redirect     = 1'b0;
        bus.redirect_target = 32'h0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    // An exception or ERET accepted this cycle squashes MTC0
                    if (bus.mtc0_wen && !exc_any && !bus.eret) begin
                        bus.cp0_data = bus.mtc0_data;
                        case (bus.mtc0_sel)
                            5'd8: begin
                                bus.cp0_control[B_BAD_WEN]    = 1'b1;
                                bus.cp0_control[B_BAD_IN_SEL] = 1'b1;
                            end
                            5'd12:   bus.cp0_control[B_STATUS_WEN] = 1'b1;
                            5'd13:   bus.cp0_control[B_CAUSE_WEN]  = 1'b1;
                            5'd14:   bus.cp0_control[B_EPC_WEN]    = 1'b1;
                            default: bus.cp0_control = 14'h0;
                        endcase
                    end
                end
                COMMIT: begin
                    bus.cp0_control[B_EPC_IN_SEL] = 1'b1;
                    bus.cp0_control[B_EPC_WEN]    = 1'b1;
                    bus.cp0_control[B_BD_WEN]     = 1'b1;
                    bus.cp0_control[B_BD_VAL]     = bd_q;
                    bus.cp0_control[B_CODE_WEN]   = 1'b1;
                    bus.cp0_control[3:1]          = code_q;
                    bus.cp0_control[B_EXL_WEN]    = 1'b1;
                    bus.cp0_control[B_EXL_VAL]    = 1'b1;
                    if (code_q == CODE_ADEL || code_q == CODE_ADES) begin
                        bus.cp0_control[B_BAD_WEN]    = 1'b1;
                        bus.cp0_control[B_BAD_IN_SEL] = 1'b1;
                        bus.cp0_data                  = bad_addr_q;
                    end
                    bus.cp0_pc = pc8_q;
                    bus.flush  = 1'b1;
                    bus.busy   = 1'b1;
                end
                REDIRECT: begin
                    bus.pc_redirect     = 1'b1;
                    bus.redirect_target = EXC_VECTOR;
                    bus.flush           = 1'b1;
                    bus.busy            = 1'b1;
                end
                ERET_R: begin
                    bus.cp0_control[B_EXL_WEN] = 1'b1;
                    bus.pc_redirect            = 1'b1;
                    bus.redirect_target        = bus.epc_in;
                    bus.flush                  = 1'b1;
                    bus.busy                   = 1'b1;
                end
                default: bus.busy = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl
//   Directed bench for exc_ctrl. A schedule-table model predicts, per cycle,
//   what the sequencer must drive: an accepted exception books a commit
//   word for the next cycle and a vector redirect for the one after; an
//   accepted ERET books an EPC redirect for the next cycle; a free cycle
//   shows the MTC0 pass-through. Literal expectations pin the model.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_ctrl_if bus ();
    exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Schedule table: kind 1 = commit, 2 = vector redirect, 3 = eret redirect
    logic [1:0]  skind [N];
    logic [13:0] sctl  [N];
    logic [31:0] sdata [N];
    logic [31:0] spc   [N];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic irq_now();
`ifdef EXC_INTERRUPT_EN
        return bus.status_in[0] && !bus.status_in[1] &&
               ((bus.cause_in[15:8] & bus.status_in[15:8]) != 8'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exc_now();
        return irq_now() || bus.exc_adel || bus.exc_ades || bus.exc_sys ||
               bus.exc_bp || bus.exc_ri || bus.exc_ov;
    endfunction

    function automatic logic [2:0] code_now();
        if (irq_now())    return 3'd0;
        if (bus.exc_adel) return 3'd1;
        if (bus.exc_ri)   return 3'd5;
        if (bus.exc_ov)   return 3'd6;
        if (bus.exc_sys)  return 3'd3;
        if (bus.exc_bp)   return 3'd4;
        return 3'd2;
    endfunction

    initial for (int i = 0; i < N; i++) skind[i] = 2'd0;

    // Model update at the edge that ends cycle cyc
    always @(posedge clk) begin
        int c1, c2;
        logic [2:0] code;
        logic is_addr;
        c1 = (cyc + 1) % N;
        c2 = (cyc + 2) % N;
        if (reset) begin
            skind[c1] = 2'd0;
            skind[c2] = 2'd0;
        end else if (skind[cyc % N] == 2'd0) begin
            if (exc_now()) begin
                code    = code_now();
                is_addr = (code == 3'd1) || (code == 3'd2);
                // EPC_IN_Sel, EXL=1, EXL_wen, BD_wen, ExcCode_wen, EPC_wen
                sctl[c1]  = 14'h2000 | 14'h0200 | 14'h0100 | 14'h0080 | 14'h0010 | 14'h0001
                          | (bus.in_delay_slot ? 14'h0040 : 14'h0)
                          | {10'h0, code, 1'b0}
                          | (is_addr ? 14'h1800 : 14'h0);
                sdata[c1] = is_addr ? bus.bad_addr : 32'h0;
                spc[c1]   = bus.pc_plus8;
                skind[c1] = 2'd1;
                skind[c2] = 2'd2;
            end else if (bus.eret) begin
                skind[c1] = 2'd3;
            end
        end
        skind[cyc % N] = 2'd0;
        cyc++;
    end

    // Compare every cycle, mid-cycle
    always @(negedge clk) begin
        logic [13:0] e_ctl;
        logic [31:0] e_data, e_pc, e_tgt;
        logic e_busy, e_flush, e_red;
        if (cyc > 0) begin
            e_ctl = 14'h0; e_data = 32'h0; e_pc = 32'h0; e_tgt = 32'h0;
            e_busy = 1'b0; e_flush = 1'b0; e_red = 1'b0;
            if (!reset) begin
                case (skind[cyc % N])
                    2'd1: begin
                        e_ctl = sctl[cyc % N]; e_data = sdata[cyc % N];
                        e_pc = spc[cyc % N]; e_busy = 1'b1; e_flush = 1'b1;
                    end
                    2'd2: begin
                        e_red = 1'b1; e_tgt = VEC; e_busy = 1'b1; e_flush = 1'b1;
                    end
                    2'd3: begin
                        e_ctl = 14'h0100; e_red = 1'b1; e_tgt = bus.epc_in;
                        e_busy = 1'b1; e_flush = 1'b1;
                    end
                    default: begin
                        if (bus.mtc0_wen && !exc_now() && !bus.eret) begin
                            e_data = bus.mtc0_data;
                            case (bus.mtc0_sel)
                                5'd8:  e_ctl = 14'h1800;
                                5'd12: e_ctl = 14'h0400;
                                5'd13: e_ctl = 14'h0020;
                                5'd14: e_ctl = 14'h0001;
                                default: e_ctl = 14'h0;
                            endcase
                        end
                    end
                endcase
            end
            check("m_cp0_control", {18'h0, bus.cp0_control}, {18'h0, e_ctl});
            check("m_cp0_data", bus.cp0_data, e_data);
            check("m_cp0_pc", bus.cp0_pc, e_pc);
            check("m_busy", {31'h0, bus.busy}, {31'h0, e_busy});
            check("m_flush", {31'h0, bus.flush}, {31'h0, e_flush});
            check("m_pc_redirect", {31'h0, bus.pc_redirect}, {31'h0, e_red});
            check("m_redirect_target", bus.redirect_target, e_tgt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.exc_adel = 0; bus.exc_ades = 0; bus.exc_sys = 0; bus.exc_bp = 0;
        bus.exc_ri = 0; bus.exc_ov = 0; bus.in_delay_slot = 0;
        bus.bad_addr = 32'h0; bus.pc_plus8 = 32'h0; bus.eret = 0;
        bus.mtc0_wen = 0; bus.mtc0_sel = 5'd0; bus.mtc0_data = 32'h0;
        bus.status_in = 32'h0; bus.cause_in = 32'h0;
    endtask

    initial begin
        logic [5:0] flags;
        reset = 1'b1;
        bus.epc_in = 32'h0;
        clear_in();
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_ctl", {18'h0, bus.cp0_control}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Ov, not in delay slot; stalled flags during COMMIT must be ignored
        bus.exc_ov = 1; bus.pc_plus8 = 32'h1008; bus.bad_addr = 32'hDEAD_BEEF;
        tick();
        clear_in();
        bus.exc_sys = 1; bus.eret = 1;
        @(negedge clk);
        check("ov_ctl", {18'h0, bus.cp0_control}, 32'h239D);
        check("ov_pc", bus.cp0_pc, 32'h1008);
        check("ov_data", bus.cp0_data, 32'h0);
        check("ov_busy1", {31'h0, bus.busy}, 32'h1);
        tick();
        clear_in();
        @(negedge clk);
        check("ov_red", {31'h0, bus.pc_redirect}, 32'h1);
        check("ov_tgt", bus.redirect_target, 32'hBFC0_0380);
        check("ov_busy2", {31'h0, bus.busy}, 32'h1);
        tick();
        @(negedge clk);
        check("ov_busy3", {31'h0, bus.busy}, 32'h0);

        // AdES in delay slot
        bus.exc_ades = 1; bus.bad_addr = 32'h8000_0003; bus.in_delay_slot = 1;
        bus.pc_plus8 = 32'h2008;
        tick();
        clear_in();
        @(negedge clk);
        check("ades_ctl", {18'h0, bus.cp0_control}, 32'h3BD5);
        check("ades_data", bus.cp0_data, 32'h8000_0003);
        tick(); tick();

        // ERET
        bus.eret = 1; bus.epc_in = 32'h0040_0020;
        tick();
        clear_in();
        @(negedge clk);
        check("eret_ctl", {18'h0, bus.cp0_control}, 32'h0100);
        check("eret_red", {31'h0, bus.pc_redirect}, 32'h1);
        check("eret_tgt", bus.redirect_target, 32'h0040_0020);
        tick();

        // MTC0 pass-through
        bus.mtc0_wen = 1; bus.mtc0_sel = 5'd12; bus.mtc0_data = 32'h0000_FF01;
        @(negedge clk);
        check("mtc0_12_ctl", {18'h0, bus.cp0_control}, 32'h0400);
        check("mtc0_12_data", bus.cp0_data, 32'h0000_FF01);
        tick();
        bus.mtc0_sel = 5'd9;
        @(negedge clk);
        check("mtc0_9_ctl", {18'h0, bus.cp0_control}, 32'h0);
        for (int s = 8; s <= 15; s++) begin
            tick();
            bus.mtc0_sel = 5'(s); bus.mtc0_data = 32'h1234_0000 + 32'(s);
        end
        tick();
        clear_in();

        // Sys + Bp + MTC0: Sys wins, MTC0 squashed
        bus.exc_sys = 1; bus.exc_bp = 1; bus.mtc0_wen = 1; bus.mtc0_sel = 5'd14;
        bus.mtc0_data = 32'h5555_AAAA; bus.pc_plus8 = 32'h3008;
        @(negedge clk);
        check("sq_ctl", {18'h0, bus.cp0_control}, 32'h0);
        tick();
        clear_in();
        @(negedge clk);
        check("sys_ctl", {18'h0, bus.cp0_control}, 32'h2397);
        tick(); tick();

        // Exception together with ERET: exception wins
        bus.exc_adel = 1; bus.exc_ov = 1; bus.eret = 1; bus.bad_addr = 32'h0000_0101;
        tick();
        clear_in();
        tick(); tick();

        // Reset during COMMIT
        bus.exc_ri = 1; bus.pc_plus8 = 32'h4008;
        tick();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rc_busy", {31'h0, bus.busy}, 32'h0);
        check("rc_ctl", {18'h0, bus.cp0_control}, 32'h0);
        tick();
        @(negedge clk);
        check("rc_red", {31'h0, bus.pc_redirect}, 32'h0);

        // Interrupt
        bus.status_in = 32'h0000_0101; bus.cause_in = 32'h0000_0100;
        bus.pc_plus8 = 32'h5008;
        tick();
        clear_in();
        @(negedge clk);
`ifdef EXC_INTERRUPT_EN
        check("irq_ctl", {18'h0, bus.cp0_control}, 32'h2391);
`else
        check("irq_ctl", {18'h0, bus.cp0_control}, 32'h0);
`endif
        tick(); tick();
        bus.status_in = 32'h0000_0103; bus.cause_in = 32'h0000_0100;
        tick();
        clear_in();
        @(negedge clk);
        check("irq_exl_busy", {31'h0, bus.busy}, 32'h0);
        tick();

        // Each single flag, alternating delay slot
        for (int k = 0; k < 6; k++) begin
            flags = 6'b1 << k;
            {bus.exc_adel, bus.exc_ades, bus.exc_sys, bus.exc_bp, bus.exc_ri, bus.exc_ov} = flags;
            bus.in_delay_slot = k[0];
            bus.bad_addr = 32'hA000_0000 + 32'(k);
            bus.pc_plus8 = 32'h0000_6000 + 32'(k * 8);
            tick();
            clear_in();
            tick(); tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
